// File: rtl/bp_be_dcache_port_arbiter_pkg.sv
// Shared types for the backend D$ port arbiter: lock state, stage-owner record
// and a fixed-priority index helper.
package bp_be_dcache_port_arbiter_pkg;

  localparam int max_num_req_gp  = 2;
  localparam int req_id_width_gp = (max_num_req_gp > 1) ? $clog2(max_num_req_gp) : 1;

  typedef enum logic {
    e_arb_idle,
    e_arb_locked
  } arb_state_e;

  typedef struct packed {
    logic                       v;
    logic [req_id_width_gp-1:0] id;
  } stage_owner_s;

  // Index of the lowest set bit; index 0 is the highest-priority requester.
  function automatic logic [req_id_width_gp-1:0] lowest_set_idx(input logic [max_num_req_gp-1:0] vec);
    lowest_set_idx = '0;
    for (int i = max_num_req_gp - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set_idx = req_id_width_gp'(i);
    end
  endfunction

endpackage

// File: rtl/bp_be_dcache_port_arbiter_if.sv
// D$ side of the arbiter: stage-0 packet handshake, stage-1 ptag and
// stage-2 early response.
interface bp_be_dcache_port_arbiter_if #(
  parameter int pkt_width_p  = 64,
  parameter int ptag_width_p = 28,
  parameter int data_width_p = 64
) ();

  logic                    v;
  logic [pkt_width_p-1:0]  pkt;
  logic                    ready;
  logic [ptag_width_p-1:0] ptag;
  logic                    ptag_v;
  logic                    early_v;
  logic [data_width_p-1:0] early_data;

  modport master (
    output v, pkt, ptag, ptag_v,
    input  ready, early_v, early_data
  );

  modport slave (
    input  v, pkt, ptag, ptag_v,
    output ready, early_v, early_data
  );

endinterface

// File: rtl/bp_be_dcache_port_arbiter_owner_pipe.sv
// Two-deep {v, id} shift register recording which requester owns the op in
// D$ stages 1 and 2, with a kill per stage transfer.
module bp_be_dcache_owner_pipe
  import bp_be_dcache_port_arbiter_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_i,
  input  stage_owner_s s0_i,
  input  logic [1:0]   kill_i,  // [0]: op entering s1, [1]: op moving s1->s2
  output stage_owner_s s1_o,
  output stage_owner_s s2_o
);

  stage_owner_s s1_q, s2_q;

  // NOTE: state is updated with non-blocking assignments so s2 captures the
  // pre-edge s1 value, giving a true shift rather than a fall-through.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q.v  <= s0_i.v & ~kill_i[0];
      s1_q.id <= s0_i.id;
      s2_q.v  <= s1_q.v & ~kill_i[1];
      s2_q.id <= s1_q.id;
    end
  end

  assign s1_o = s1_q;
  assign s2_o = s2_q;

endmodule

// File: rtl/bp_be_dcache_port_arbiter.sv
// Shares the single D$ request port among backend requesters with fixed
// priority, an ownership lock, and per-stage owner tracking for steering.
module bp_be_dcache_port_arbiter
  import bp_be_dcache_port_arbiter_pkg::*;
#(
  parameter int                   num_req_p     = 2,
  parameter int                   pkt_width_p   = 64,
  parameter int                   ptag_width_p  = 28,
  parameter int                   data_width_p  = 64,
  parameter logic [num_req_p-1:0] flush_mask_p  = 2'b10,
  localparam int                  lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              flush_i,

  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*pkt_width_p-1:0]  req_pkt_i,
  input  logic [num_req_p-1:0]              req_lock_i,
  output logic [num_req_p-1:0]              req_yumi_o,
  input  logic [num_req_p*ptag_width_p-1:0] req_ptag_i,
  input  logic [num_req_p-1:0]              req_ptag_v_i,
  output logic [num_req_p-1:0]              req_early_v_o,
  output logic [data_width_p-1:0]           early_data_o,

  bp_be_dcache_port_arbiter_if.master       dcache,

  output logic                              lock_owner_v_o,
  output logic [lg_num_req_lp-1:0]          lock_owner_o
);

  if (num_req_p > max_num_req_gp) begin : g_bad_num_req
    $error("num_req_p exceeds max_num_req_gp in bp_be_dcache_port_arbiter_pkg");
  end

  arb_state_e               state_q, state_n;
  logic [lg_num_req_lp-1:0] owner_q, owner_n;
  logic [num_req_p-1:0]     flush_kill, lock_mask, cand, win_oh;
  logic [lg_num_req_lp-1:0] win_id, s1_id, s2_id;
  stage_owner_s             s0, s1, s2;

  // Stage 0: candidates are masked by lock ownership and by flush of masked requesters.
  assign flush_kill = flush_i ? flush_mask_p : '0;
  assign lock_mask  = (state_q == e_arb_locked) ? (num_req_p'(1) << owner_q) : '1;
  assign cand       = req_v_i & lock_mask & ~flush_kill & {num_req_p{~reset_i}};
  assign win_oh     = cand & ~(cand - num_req_p'(1));
  assign win_id     = lg_num_req_lp'(lowest_set_idx(max_num_req_gp'(cand)));

  assign dcache.v   = |cand;
  assign req_yumi_o = win_oh & {num_req_p{dcache.ready}};

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path leaves a value held and no latch is inferred.
  always_comb begin
    dcache.pkt = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (win_oh[i]) dcache.pkt |= req_pkt_i[i*pkt_width_p +: pkt_width_p];
    end
  end

  assign s0 = '{v: |req_yumi_o, id: req_id_width_gp'(win_id)};

  bp_be_dcache_owner_pipe u_owner_pipe (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .s0_i    (s0),
    .kill_i  ({flush_kill[s1_id], flush_kill[win_id]}),
    .s1_o    (s1),
    .s2_o    (s2)
  );

  assign s1_id = lg_num_req_lp'(s1.id);
  assign s2_id = lg_num_req_lp'(s2.id);

  always_comb begin
    dcache.ptag = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (s1_id == lg_num_req_lp'(i)) dcache.ptag = req_ptag_i[i*ptag_width_p +: ptag_width_p];
    end
  end
  assign dcache.ptag_v = s1.v & req_ptag_v_i[s1_id];

  // Stage 2: early valid with no tracked owner is dropped.
  always_comb begin
    req_early_v_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      req_early_v_o[i] = s2.v & (s2_id == lg_num_req_lp'(i)) & dcache.early_v;
    end
  end
  assign early_data_o = dcache.early_data;

  always_comb begin
    state_n = state_q;
    owner_n = owner_q;
    case (state_q)
      e_arb_idle: begin
        if ((|req_yumi_o) && req_lock_i[win_id]) begin
          state_n = e_arb_locked;
          owner_n = win_id;
        end
      end
      e_arb_locked: begin
        // Release waits until the owner has no op left in s1 or s2.
        if (flush_kill[owner_q]) begin
          state_n = e_arb_idle;
        end else if (!req_lock_i[owner_q]
                     && !(s1.v && s1_id == owner_q)
                     && !(s2.v && s2_id == owner_q)) begin
          state_n = e_arb_idle;
        end
      end
      default: state_n = e_arb_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_arb_idle;
      owner_q <= '0;
    end else begin
      state_q <= state_n;
      owner_q <= owner_n;
    end
  end

  assign lock_owner_v_o = (state_q == e_arb_locked);
  assign lock_owner_o   = lock_owner_v_o ? owner_q : '0;

  a_yumi_onehot0 : assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(req_yumi_o));

  a_lock_exclusive : assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == e_arb_locked) |-> ((req_yumi_o & ~lock_mask) == '0));

endmodule

// File: tb/tb_bp_be_dcache_port_arbiter.sv
// Directed bench for the D$ port arbiter; early responses are checked every
// cycle against a queue of expected owners scheduled two cycles after grant.
module tb_bp_be_dcache_port_arbiter;

  localparam int num_req_lp = 2;
  localparam int pkt_w_lp   = 64;
  localparam int ptag_w_lp  = 28;
  localparam int data_w_lp  = 64;

  localparam logic [63:0] pkt_a = 64'hA0A0_1111_2222_0001;
  localparam logic [63:0] pkt_b = 64'hB0B0_3333_4444_0002;

  typedef struct {
    int         cyc;
    logic [1:0] oh;
  } exp_early_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                            reset, flush;
  logic [num_req_lp-1:0]           req_v, req_lock, req_ptag_v, req_yumi, req_early_v;
  logic [num_req_lp*pkt_w_lp-1:0]  req_pkt;
  logic [num_req_lp*ptag_w_lp-1:0] req_ptag;
  logic [data_w_lp-1:0]            early_data;
  logic                            lock_owner_v;
  logic [0:0]                      lock_owner;

  bp_be_dcache_port_arbiter_if #(
    .pkt_width_p (pkt_w_lp),
    .ptag_width_p(ptag_w_lp),
    .data_width_p(data_w_lp)
  ) dc_if ();

  bp_be_dcache_port_arbiter #(
    .num_req_p   (num_req_lp),
    .pkt_width_p (pkt_w_lp),
    .ptag_width_p(ptag_w_lp),
    .data_width_p(data_w_lp),
    .flush_mask_p(2'b10)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .flush_i       (flush),
    .req_v_i       (req_v),
    .req_pkt_i     (req_pkt),
    .req_lock_i    (req_lock),
    .req_yumi_o    (req_yumi),
    .req_ptag_i    (req_ptag),
    .req_ptag_v_i  (req_ptag_v),
    .req_early_v_o (req_early_v),
    .early_data_o  (early_data),
    .dcache        (dc_if),
    .lock_owner_v_o(lock_owner_v),
    .lock_owner_o  (lock_owner)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         mon_en   = 1'b0;
  exp_early_t exp_q[$];
  logic [1:0] exp_early;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: an op granted in cycle N must surface on its owner in N+2.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_early = 2'b00;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_early = exp_q[0].oh;
        void'(exp_q.pop_front());
      end
      check("early_route", 64'(req_early_v), 64'(exp_early));
    end
  end

  task automatic push_exp(input int id);
    exp_q.push_back('{cyc: cyc + 2, oh: 2'(1 << id)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    req_v      = '0;
    req_lock   = '0;
    req_ptag_v = '0;
    flush      = 1'b0;
    dc_if.ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    req_pkt          = {pkt_b, pkt_a};
    req_ptag         = {28'h0ABCDEF, 28'h1234567};
    dc_if.early_v    = 1'b1;
    dc_if.early_data = 64'h0;
    idle();
    tick(); tick(); settle();
    check("rst_dcache_v", 64'(dc_if.v), 0);
    check("rst_pkt", dc_if.pkt, 0);
    check("rst_yumi", 64'(req_yumi), 0);
    check("rst_ptag_v", 64'(dc_if.ptag_v), 0);
    check("rst_early_v", 64'(req_early_v), 0);
    check("rst_lock_v", 64'(lock_owner_v), 0);
    check("rst_lock_owner", 64'(lock_owner), 0);
    mon_en = 1'b1;
    tick(); reset = 1'b0;
    tick();

    // Contention: req0 first, then req1.
    req_v = 2'b11; settle();
    check("t1_yumi0", 64'(req_yumi), 64'h1);
    check("t1_v", 64'(dc_if.v), 1);
    check("t1_pkt0", dc_if.pkt, pkt_a);
    push_exp(0);
    tick(); req_v = 2'b10; settle();
    check("t1_yumi1", 64'(req_yumi), 64'h2);
    check("t1_pkt1", dc_if.pkt, pkt_b);
    push_exp(1);
    tick(); req_v = 2'b00; dc_if.early_data = 64'hDEAD_BEEF_0000_0042; settle();
    check("t1_idle_v", 64'(dc_if.v), 0);
    check("t1_idle_pkt", dc_if.pkt, 0);
    check("t1_early_data", early_data, 64'hDEAD_BEEF_0000_0042);
    tick(); tick();

    // Ptag steering to the stage-1 owner.
    req_v = 2'b10; settle();
    check("t2_yumi", 64'(req_yumi), 64'h2);
    push_exp(1);
    tick(); req_ptag_v = 2'b10; settle();
    check("t2_ptag", 64'(dc_if.ptag), 64'h0ABCDEF);
    check("t2_ptag_v", 64'(dc_if.ptag_v), 1);
    push_exp(1);
    tick(); req_v = 2'b00; req_ptag_v = 2'b01; settle();
    check("t2_ptag_owner", 64'(dc_if.ptag), 64'h0ABCDEF);
    check("t2_ptag_v_other", 64'(dc_if.ptag_v), 0);
    tick(); req_ptag_v = 2'b11; settle();
    check("t2_ptag_v_empty", 64'(dc_if.ptag_v), 0);
    tick(); idle(); tick(); tick();

    // Lock held by req0 blocks req1 until released with nothing in flight.
    req_v = 2'b01; req_lock = 2'b01; settle();
    check("t3_yumi_lock", 64'(req_yumi), 64'h1);
    check("t3_lock_v_pre", 64'(lock_owner_v), 0);
    push_exp(0);
    for (int i = 1; i <= 4; i++) begin
      tick(); req_v = 2'b10; settle();
      check("t3_blocked_yumi", 64'(req_yumi), 0);
      check("t3_lock_v", 64'(lock_owner_v), 1);
      check("t3_lock_owner", 64'(lock_owner), 0);
    end
    tick(); req_lock = 2'b00; settle();
    check("t3_release_cycle_yumi", 64'(req_yumi), 0);
    check("t3_release_cycle_lock_v", 64'(lock_owner_v), 1);
    tick(); settle();
    check("t3_idle_lock_v", 64'(lock_owner_v), 0);
    check("t3_req1_yumi", 64'(req_yumi), 64'h2);
    push_exp(1);
    tick(); idle(); tick(); tick();

    // Lock drop deferred while the owner's op is still in s1/s2.
    req_v = 2'b01; req_lock = 2'b01; settle();
    push_exp(0);
    tick(); req_v = 2'b10; req_lock = 2'b00; settle();
    check("t3b_s1_busy", 64'(req_yumi), 0);
    tick(); settle();
    check("t3b_s2_busy", 64'(req_yumi), 0);
    tick(); settle();
    check("t3b_release_cycle", 64'(req_yumi), 0);
    tick(); settle();
    check("t3b_req1_yumi", 64'(req_yumi), 64'h2);
    push_exp(1);
    tick(); idle(); tick(); tick();

    // Flush: req1 op in s1 dies, req0 op in s2 still completes.
    req_v = 2'b01; settle();
    push_exp(0);
    tick(); req_v = 2'b10; settle();
    check("t4_yumi_req1", 64'(req_yumi), 64'h2);
    tick(); flush = 1'b1; settle();
    check("t4_flush_yumi", 64'(req_yumi), 0);
    check("t4_flush_v", 64'(dc_if.v), 0);
    tick(); idle(); tick(); tick();

    // PTW still granted during flush.
    req_v = 2'b11; flush = 1'b1; settle();
    check("t4_ptw_yumi", 64'(req_yumi), 64'h1);
    check("t4_ptw_pkt", dc_if.pkt, pkt_a);
    push_exp(0);
    tick(); idle(); tick(); tick();

    // Lock held by req1 blocks req0, then flush drops it.
    req_v = 2'b10; req_lock = 2'b10; settle();
    push_exp(1);
    tick(); req_v = 2'b11; settle();
    check("t4_lock1_yumi", 64'(req_yumi), 64'h2);
    check("t4_lock1_owner", 64'(lock_owner), 1);
    tick(); flush = 1'b1; settle();
    check("t4_lock1_flush_yumi", 64'(req_yumi), 0);
    check("t4_lock1_flush_lock_v", 64'(lock_owner_v), 1);
    tick(); flush = 1'b0; req_lock = 2'b00; req_v = 2'b01; settle();
    check("t4_after_flush_lock_v", 64'(lock_owner_v), 0);
    check("t4_after_flush_yumi", 64'(req_yumi), 64'h1);
    push_exp(0);
    tick(); idle(); tick(); tick();

    // Backpressure: valid held without yumi until ready.
    dc_if.ready = 1'b0; req_v = 2'b01; req_ptag_v = 2'b11;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t5_bp_v", 64'(dc_if.v), 1);
      check("t5_bp_yumi", 64'(req_yumi), 0);
      if (i > 0) check("t5_bp_s1", 64'(dc_if.ptag_v), 0);
      tick();
    end
    dc_if.ready = 1'b1; settle();
    check("t5_ready_yumi", 64'(req_yumi), 64'h1);
    check("t5_ready_s1", 64'(dc_if.ptag_v), 0);
    push_exp(0);
    tick(); req_v = 2'b00; settle();
    check("t5_s1_after_yumi", 64'(dc_if.ptag_v), 1);
    tick(); idle(); tick(); tick();

    // Reset mid-lock with s1 and s2 valid.
    req_v = 2'b01; req_lock = 2'b01; settle();
    push_exp(0);
    tick(); settle();
    check("t6_locked_yumi", 64'(req_yumi), 64'h1);
    check("t6_locked_v", 64'(lock_owner_v), 1);
    push_exp(0);
    tick(); reset = 1'b1; req_v = 2'b00;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc) void'(exp_q.pop_back());
    tick(); reset = 1'b0; req_lock = 2'b00; req_ptag_v = 2'b11; settle();
    check("t6_dcache_v", 64'(dc_if.v), 0);
    check("t6_yumi", 64'(req_yumi), 0);
    check("t6_ptag_v", 64'(dc_if.ptag_v), 0);
    check("t6_lock_v", 64'(lock_owner_v), 0);
    check("t6_lock_owner", 64'(lock_owner), 0);
    check("t6_early_v", 64'(req_early_v), 0);
    tick(); req_ptag_v = 2'b00; req_v = 2'b10; settle();
    check("t6_idle_grant", 64'(req_yumi), 64'h2);
    push_exp(1);
    tick(); idle();
    for (int i = 0; i < 4; i++) tick();

    check("sb_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_be_dcache_port_arbiter.md
Name: bp_be_dcache_port_arbiter

Overview:
- Shares the single D$ request port (pkt in stage 0, ptag in stage 1, early data in stage 2) among several backend requesters: page-table walker, memory pipe, and future ones.
- Grants with fixed priority plus an optional ownership lock.
- Tracks which requester owns each in-flight D$ stage, so the stage-1 ptag and stage-2 early response are steered to the correct owner.
- Sits between the requesters and bp_be_dcache inside the memory pipe.

Parameters:
- num_req_p, 2, number of requesters. Index 0 has the highest priority (PTW).
- pkt_width_p, 64, width of the D$ packet, which is opaque to the arbiter.
- ptag_width_p, 28, physical tag width.
- data_width_p, 64, early data width.
- flush_mask_p, 2'b10, per-requester bit. When set, flush_i kills that requester's in-flight ops.
- lg_num_req_lp, localparam, `BSG_SAFE_CLOG2(num_req_p).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset. One clock; reset is synchronous, active-high.
- flush_i  in  1  pipeline flush.
- req_v_i  in  num_req_p  per-requester packet valid.
- req_pkt_i  in  num_req_p*pkt_width_p  per-requester packets.
- req_lock_i  in  num_req_p  per-requester request to hold exclusive ownership.
- req_yumi_o  out  num_req_p  one-hot; packet accepted this cycle.
- req_ptag_i  in  num_req_p*ptag_width_p  per-requester ptag, presented the cycle after yumi.
- req_ptag_v_i  in  num_req_p  per-requester ptag valid.
- req_early_v_o  out  num_req_p  early-response valid, routed to the owner.
- early_data_o  out  data_width_p  early data, broadcast to all requesters.
- dcache_v_o  out  1  packet valid to D$.
- dcache_pkt_o  out  pkt_width_p  granted packet.
- dcache_ready_i  in  1  D$ ready.
- dcache_ptag_o  out  ptag_width_p  stage-1 ptag.
- dcache_ptag_v_o  out  1  stage-1 ptag valid.
- dcache_early_v_i  in  1  D$ early valid.
- dcache_early_data_i  in  data_width_p  D$ early data.
- lock_owner_v_o  out  1  arbiter is in the LOCKED state.
- lock_owner_o  out  lg_num_req_lp  current lock owner.

Behaviour:
Reset:
- All outputs are 0.
- The state machine is IDLE and both stage valids are cleared.

Grant (combinational, stage 0):
- The candidate set is req_v_i, masked by state. In IDLE, all requesters are candidates. In LOCKED(k), only requester k is a candidate.
- The winner is the lowest-index candidate.
- dcache_v_o = |candidates.
- dcache_pkt_o = the winner's packet, or 0 when there is no candidate.
- req_yumi_o = onehot(winner) & dcache_ready_i.
- There is no combinational path from dcache_ready_i to dcache_v_o.

Stage tracking (registered):
- On yumi: s1_v <= 1 and s1_id <= winner. Otherwise s1_v <= 0.
- Every cycle: s2_v <= s1_v and s2_id <= s1_id.

Stage 1 ptag steering:
- dcache_ptag_o = req_ptag_i[s1_id].
- dcache_ptag_v_o = s1_v & req_ptag_v_i[s1_id].

Stage 2 response routing:
- req_early_v_o[i] = s2_v & (s2_id == i) & dcache_early_v_i.
- A D$ early_v with s2_v == 0 is dropped.

Lock state machine:
- IDLE -> LOCKED(w) when a yumi is given to w with req_lock_i[w] = 1.
- LOCKED(k) -> IDLE when req_lock_i[k] = 0 and no op owned by k remains in s1 or s2. The release cycle is the first cycle that op-free condition holds; the next grant happens in the following cycle.
- In LOCKED(k), higher-priority requesters are also blocked. The lock is never preempted.
- If req_lock_i[w] rises without a yumi, the state does not change.

Flush:
- For each stage whose owner has flush_mask_p[id] = 1, clear its valid in the same edge.
- While flush_i is asserted, stage-0 grants to masked requesters are suppressed: that requester's yumi = 0 and it is not a candidate.
- Unmasked ops, such as PTW ops, proceed untouched.
- A lock held by a masked requester is dropped to IDLE on flush.

Simultaneous events:
- A grant and a release in the same cycle: the release takes effect next cycle.
- A yumi in the same cycle as flush is impossible for masked requesters.

Assertions:
- req_yumi_o is one-hot0.
- Under lock, no yumi goes to a requester other than k.

Decomposition:
- The stage-owner record {v, id} struct goes in bp_be_pkg.
- The lock state enum {e_arb_idle, e_arb_locked} also goes in bp_be_pkg.
- Fixed-priority selection uses bsg_priority_encode with bsg_mux_one_hot; no new sub-module is needed.
- The stage shift register is a single natural sub-module, bp_be_dcache_owner_pipe (2-deep {v, id} pipe with per-stage kill).

Test Plan:
1. Contention: req_v_i = 2'b11, dcache_ready_i = 1, no locks.
   - yumi = 2'b01; dcache_pkt_o = pkt0.
   - The next cycle grants req1.
   - dcache_early_v_i pulses at t+2 and t+3, producing req_early_v_o = 01 then 10.
2. Ptag steering: req1 granted at t, req_ptag_i[1] = 28'h0ABCDEF, req_ptag_v_i = 2'b10 at t+1.
   - dcache_ptag_o = 28'h0ABCDEF and dcache_ptag_v_o = 1.
   - Req0's ptag is ignored.
3. Lock: req0 granted with lock = 1, then req_v_i = 2'b10 for 5 cycles with lock held.
   - No yumi to req1; lock_owner_v_o = 1 and lock_owner_o = 0.
   - Lock drops at t+5 with no in-flight ops: IDLE at t+6 and req1 yumi at t+6.
4. Flush: req1 op in s1 and a req0 op in s2, flush_i pulse.
   - The req1 op never produces an early_v.
   - The req0 op's early_v is still delivered.
   - A req1 yumi in the flush cycle is 0.
5. Backpressure: dcache_ready_i = 0 with req_v_i = 01 for 3 cycles.
   - dcache_v_o = 1 and yumi = 0 each cycle; s1_v stays 0.
   - ready = 1 on the 4th cycle: yumi = 01.
6. Reset: reset_i asserted mid-lock with s1/s2 valid.
   - The next cycle has all outputs 0, state IDLE, and a stray dcache_early_v_i is dropped.
